mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-port unified instruction/data memory between the pipeline's Fetch stage (instruction reads) and Memory stage (load/store). It issues one memory transaction at a time and returns read data to the winning requester. It generates stall_f / stall_m so the hazard logic can freeze the affected stages. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch address (PCF)
- if_rdata  out  DATA_W  fetched instruction, meaningful when if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- stall_f  out  1  fetch must hold
- dm_req  in  1  data request (load or store in M stage); held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALUResultM)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, meaningful when dm_valid and load
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- stall_m  out  1  memory stage must hold
- mem_req  out  1  memory transaction request (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  ADDR_W  address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready

## Operation
- FSM states: IDLE, D_BUSY, I_BUSY, RESP.
- IDLE, grant decision:
  - data wins if dm_req && (!if_req || streak < MAX_D_STREAK);
  - else fetch wins if if_req;
  - else stay in IDLE.
- On a grant, the FSM latches addr/we/wdata into the mem_* registers and sets mem_req=1.
  - Data grant: mem_we=dm_we, mem_wdata=dm_wdata; go to D_BUSY.
  - Fetch grant: mem_we=0; go to I_BUSY.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - +1 on a data grant with if_req high;
  - cleared on a data grant with if_req low;
  - cleared on a fetch grant.
- D_BUSY / I_BUSY: mem_req and the mem_* fields are held stable until a cycle with mem_ready=1. That cycle:
  - capture mem_rdata into the owner's rdata register;
  - clear mem_req;
  - go to RESP.
- RESP: assert the owner's valid for exactly one cycle; no new grant is issued; go to IDLE.
- stall_f = if_req && !if_valid; stall_m = dm_req && !dm_valid. Both are combinational from inputs and registered valids.
- Withdrawn request (flush drops if_req mid-transaction): the transaction still completes and valid still pulses; the requester ignores it.
- For a store, dm_rdata holds mem_rdata as captured (don't care to the pipeline).
- if_rdata / dm_rdata hold their last captured value until the next completion for that owner.

## Timing
- Reset values: state=IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0. stall_f/stall_m follow their equations, i.e. equal the request inputs.
- Reset during D_BUSY/I_BUSY/RESP abandons the transaction. mem_req is 0 in the first cycle after reset, and no valid pulse is produced for the abandoned access.
- Minimum latency, request seen in IDLE at cycle 0 with mem_ready tied high:
  - mem_req=1 in cycle 1;
  - completion at the end of cycle 1;
  - valid=1 in cycle 2 (stall low in cycle 2);
  - IDLE in cycle 3.
- Best-case throughput: one access per 3 cycles.
- Each extra cycle mem_ready is low adds one cycle of latency.
- Simultaneous if_req and dm_req in IDLE: the data access is served first unless streak == MAX_D_STREAK, in which case the fetch is served.
- Requests arriving in RESP are not granted until the following IDLE cycle.

## Test plan
- Lone fetch, mem_ready=1, if_addr=0x10, mem_rdata=0x00500093 → mem_req cycle 1 with mem_addr=0x10 and mem_we=0; if_valid and if_rdata=0x00500093 in cycle 2; stall_f high cycles 0–1, low cycle 2.
- Store, dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles → mem_addr/mem_wdata/mem_we=1 held stable for 4 cycles; dm_valid one cycle after mem_ready; stall_m high throughout until then.
- Simultaneous if_req and dm_req (load 0x80) from reset → data granted first. The fetch is granted in the IDLE following RESP, so if_valid arrives 3 cycles after dm_valid.
- Continuous dm_req with if_req held, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I grant.
- Reset asserted while I_BUSY with mem_ready low → mem_req=0 next cycle, no if_valid, state IDLE; a new fetch after reset completes normally.
- if_req dropped during I_BUSY → transaction completes, if_valid pulses once, then IDLE with no re-issue.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between instruction fetch
// and the memory stage (load/store). One transaction is in flight at a time.
// Data accesses win ties. A streak counter bounds how many data grants in a
// row can pass a waiting fetch, so fetch always makes progress.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request, held until if_valid
//   if_rdata/if_valid        fetched word and one-cycle completion pulse
//   stall_f                  fetch stage must hold
//   dm_req/dm_we/dm_addr/dm_wdata  load/store request, held until dm_valid
//   dm_rdata/dm_valid        load data and one-cycle completion pulse
//   stall_m                  memory stage must hold
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory transaction
//   mem_ready/mem_rdata      memory completion handshake and read data
//
// state  | meaning
// IDLE   | free; grant decision made this cycle
// D_BUSY | data transaction on the memory port, waiting for mem_ready
// I_BUSY | fetch transaction on the memory port, waiting for mem_ready
// RESP   | owner's valid is high; no grant this cycle
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_f,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          d_win;
  logic          i_win;

  // Once streak reaches the limit, a pending fetch beats a pending data access.
  assign d_win = dm_req && (!if_req || (streak < STREAK_MAX));
  assign i_win = !d_win && if_req;

  assign stall_f = if_req && !if_valid;
  assign stall_m = dm_req && !dm_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // valids are single-cycle pulses; they are raised only on completion
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            streak    <= if_req ? streak + 1'b1 : '0;
            state     <= D_BUSY;
          end else if (i_win) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            streak   <= '0;
            state    <= I_BUSY;
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        I_BUSY: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized requesters
// and a randomized memory, all checked cycle by cycle against a transaction
// level model (grant rule, streak count, and completion timing).
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          stall_f;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          stall_m;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_f(stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: which requester owns the port, when the arbiter may next
  // decide a grant, and what the outputs must be in the coming cycle.
  bit            m_armed = 0;
  bit            m_busy;
  bit            m_owner_d;
  int            m_streak;
  int            m_idle_from;
  logic          e_mem_req, e_mem_we, e_if_valid, e_dm_valid;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;
  bit            e_fld;  // mem_addr/mem_we are defined next cycle
  bit            e_wd;   // mem_wdata is defined next cycle

  // DUT observations used by directed scenarios
  logic          prev_mem_req = 1'b0;
  logic [AW-1:0] grant_log[$];
  int            n_iv, n_dv, iv_cyc, dv_cyc;

  task automatic sample();
    @(negedge clk);
    if (m_armed) begin
      check_val("mem_req",  64'(mem_req),  64'(e_mem_req));
      check_val("if_valid", 64'(if_valid), 64'(e_if_valid));
      check_val("dm_valid", 64'(dm_valid), 64'(e_dm_valid));
      check_val("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
      check_val("dm_rdata", 64'(dm_rdata), 64'(e_dm_rdata));
      if (e_fld) begin
        check_val("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
        check_val("mem_we",   64'(mem_we),   64'(e_mem_we));
      end
      if (e_wd) check_val("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
    end
    if (mem_req && !prev_mem_req) grant_log.push_back(mem_addr);
    prev_mem_req = mem_req;
    if (if_valid) begin n_iv++; iv_cyc = cyc; end
    if (dm_valid) begin n_dv++; dv_cyc = cyc; end
  endtask

  // Called after the inputs for the current cycle are driven.
  task automatic commit();
    #1;
    if (m_armed) begin
      check_val("stall_f", 64'(stall_f), 64'(if_req && !e_if_valid));
      check_val("stall_m", 64'(stall_m), 64'(dm_req && !e_dm_valid));
    end
    if (rst) begin
      m_armed = 1; m_busy = 0; m_streak = 0; m_idle_from = cyc + 1;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_valid = 0; e_dm_valid = 0; e_if_rdata = '0; e_dm_rdata = '0;
      e_fld = 1; e_wd = 1;
    end else if (m_armed) begin
      e_if_valid = 0;
      e_dm_valid = 0;
      if (m_busy) begin
        if (mem_ready) begin
          if (m_owner_d) begin e_dm_valid = 1; e_dm_rdata = mem_rdata; end
          else begin e_if_valid = 1; e_if_rdata = mem_rdata; end
          m_busy = 0; e_mem_req = 0; e_fld = 0; e_wd = 0;
          m_idle_from = cyc + 2;  // one response cycle, then free
        end
      end else if (cyc >= m_idle_from) begin
        if (dm_req && (!if_req || m_streak < MAXS)) begin
          m_busy = 1; m_owner_d = 1;
          e_mem_req = 1; e_mem_addr = dm_addr; e_mem_we = dm_we; e_mem_wdata = dm_wdata;
          e_fld = 1; e_wd = 1;
          m_streak = if_req ? m_streak + 1 : 0;
        end else if (if_req) begin
          m_busy = 1; m_owner_d = 0;
          e_mem_req = 1; e_mem_addr = if_addr; e_mem_we = 0;
          e_fld = 1; e_wd = 0;
          m_streak = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic clear_obs();
    grant_log.delete();
    n_iv = 0; n_dv = 0; iv_cyc = -100; dv_cyc = -100;
  endtask

  task automatic do_reset();
    sample();
    rst = 1; if_req = 0; dm_req = 0; mem_ready = 0;
    commit();
    sample();
    rst = 0;
    commit();
  endtask

  // Runs n cycles with the current drive; requesters drop on their valid if asked.
  task automatic run_dir(input int n, input bit drop_i, input bit drop_d);
    for (int k = 0; k < n; k++) begin
      sample();
      if (drop_i && if_valid) if_req = 0;
      if (drop_d && dm_valid) dm_req = 0;
      commit();
    end
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; mem_ready = 0; mem_rdata = '0;
    clear_obs();
    do_reset();

    // Lone fetch, memory always ready
    clear_obs();
    sample();
    if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h00500093;
    commit();
    run_dir(4, 1, 0);
    check_val("t1_if_valid_count", 64'(n_iv), 64'd1);
    check_val("t1_if_rdata", 64'(if_rdata), 64'h00500093);

    // Store with mem_ready withheld for three cycles of the transaction
    clear_obs();
    sample();
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; mem_ready = 0;
    commit();
    run_dir(3, 0, 1);
    sample();
    check_val("t2_mem_req_held", 64'(mem_req), 64'd1);
    check_val("t2_mem_wdata_held", 64'(mem_wdata), 64'hDEADBEEF);
    mem_ready = 1;
    commit();
    run_dir(3, 0, 1);
    check_val("t2_dm_valid_count", 64'(n_dv), 64'd1);

    // Simultaneous fetch and load from reset: load first, fetch three cycles later
    do_reset();
    clear_obs();
    sample();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    mem_ready = 1; mem_rdata = 32'h1234;
    commit();
    run_dir(8, 1, 1);
    check_val("t3_valid_gap", 64'(iv_cyc - dv_cyc), 64'd3);
    check_val("t3_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : '1), 64'h80);

    // Both requesters held: four data grants per fetch grant
    do_reset();
    clear_obs();
    sample();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h80; mem_ready = 1;
    commit();
    run_dir(31, 0, 0);
    check_val("t4_grant_count", 64'(grant_log.size() >= 10), 64'd1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      check_val($sformatf("t4_grant_%0d", i), 64'(grant_log[i]),
                (i % 5 == 4) ? 64'h10 : 64'h80);

    // Reset while a fetch waits on memory, then a fresh fetch completes
    do_reset();
    clear_obs();
    sample();
    dm_req = 0; if_req = 1; if_addr = 32'h20; mem_ready = 0;
    commit();
    run_dir(2, 0, 0);
    sample();
    rst = 1;
    commit();
    sample();
    rst = 0;
    check_val("t5_mem_req_after_rst", 64'(mem_req), 64'd0);
    check_val("t5_no_if_valid", 64'(n_iv), 64'd0);
    if_addr = 32'h24; mem_ready = 1; mem_rdata = 32'h5555;
    commit();
    run_dir(5, 1, 0);
    check_val("t5_refetch_valid", 64'(n_iv), 64'd1);
    check_val("t5_refetch_data", 64'(if_rdata), 64'h5555);

    // Fetch withdrawn mid-transaction: still one valid, no re-issue
    clear_obs();
    sample();
    if_req = 1; if_addr = 32'h30; mem_ready = 0; mem_rdata = 32'h7777;
    commit();
    sample();
    if_req = 0;
    commit();
    run_dir(1, 0, 0);
    sample();
    mem_ready = 1;
    commit();
    run_dir(6, 0, 0);
    check_val("t6_if_valid_count", 64'(n_iv), 64'd1);
    check_val("t6_grant_count", 64'(grant_log.size()), 64'd1);

    // Randomized requesters, memory and occasional reset
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      sample();
      rst = ($urandom_range(0, 299) == 0);
      if (if_req && if_valid) if_req = 0;
      else if (if_req && $urandom_range(0, 99) < 3) if_req = 0;
      if (!if_req && $urandom_range(0, 99) < 40) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req && dm_valid) dm_req = 0;
      if (!dm_req && $urandom_range(0, 99) < 50) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 99) < 60);
      mem_rdata = $urandom;
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
